register_file: RTL
==================

Name: register_file

Overview:
- Architectural register file with per-register rename tags. Sits directly downstream of the dispatcher and is committed to by the reorder buffer.
- Serves the dispatcher's combinational operand lookups (Qj/Qk, Vj/Vk).
- Records rd→RoB renames from dispatch and retires values on RoB commit.
- Drops all pending renames on a branch mispredict.

Parameters:
REG_WIDTH, 5, architectural register index width (32 registers)
EX_REG_WIDTH, 6, register index width including the "no register" code
NON_REG, 32, index meaning "no register"
RoB_WIDTH, 4, RoB index width (16 entries)
EX_RoB_WIDTH, 5, tag width including the "no dependency" code
NON_DEP, 16, tag meaning "value valid in register file"

Ports:
Sys_clk  in  1  clock, rising edge
Sys_rst_n  in  1  asynchronous active-low reset
Sys_rdy  in  1  global enable; state holds when low
DPRF_rs1  in  EX_REG_WIDTH  operand-1 lookup index (NON_REG = unused)
DPRF_rs2  in  EX_REG_WIDTH  operand-2 lookup index (NON_REG = unused)
RFDP_Qj  out  EX_RoB_WIDTH  operand-1 producer tag, or NON_DEP
RFDP_Qk  out  EX_RoB_WIDTH  operand-2 producer tag, or NON_DEP
RFDP_Vj  out  32  operand-1 value (meaningful when RFDP_Qj == NON_DEP)
RFDP_Vk  out  32  operand-2 value (meaningful when RFDP_Qk == NON_DEP)
DPRF_en  in  1  rename request this cycle
DPRF_rd  in  EX_REG_WIDTH  register being renamed (NON_REG = none)
DPRF_RoB_index  in  RoB_WIDTH  RoB entry that will produce rd
RoBRF_en  in  1  commit this cycle
RoBRF_rd  in  EX_REG_WIDTH  committed destination (NON_REG = none)
RoBRF_RoB_index  in  RoB_WIDTH  RoB entry being committed
RoBRF_value  in  32  committed value
RoBRF_pre_judge  in  1  0 = mispredict flush this cycle, 1 = normal

Behaviour:
- State: value[0..31] (32 bits each) and tag[0..31] (EX_RoB_WIDTH bits each).
- Reset (Sys_rst_n low, asynchronous): all values 0, all tags NON_DEP. Outputs are combinational, so after reset they read Q=NON_DEP and V=0 for any index.
- x0: value is always 0 and its tag is always NON_DEP. Rename and commit targeting x0 are ignored, both in state and in bypass.
- Lookup (combinational, per operand, rs = DPRF_rs1 or DPRF_rs2), priority order:
  1. rs == NON_REG or rs == 0 → Q=NON_DEP, V=0.
  2. RoBRF_pre_judge == 0 → Q=NON_DEP, V=value[rs], with the commit bypass of case 4 still applied to V.
  3. DPRF_en && DPRF_rd == rs → Q={0,DPRF_RoB_index}, V=0. Rename bypass: the previous instruction's rename lands this edge.
  4. RoBRF_en && RoBRF_rd == rs && tag[rs] == {0,RoBRF_RoB_index} → Q=NON_DEP, V=RoBRF_value. Commit bypass.
  5. Otherwise → Q=tag[rs], V=value[rs].
- Posedge update, only when Sys_rdy is high; otherwise all state holds:
  - Commit: if RoBRF_en and RoBRF_rd is neither NON_REG nor 0, then value[rd] <= RoBRF_value. The value is written regardless of tag match; this includes the flush cycle, so a committing jal/jalr still writes.
  - Commit tag clear: tag[rd] <= NON_DEP only if tag[rd] == {0,RoBRF_RoB_index}. A younger rename has already overwritten the tag and must be kept.
  - Rename: if DPRF_en, RoBRF_pre_judge == 1, and DPRF_rd is neither NON_REG nor 0, then tag[DPRF_rd] <= {0,DPRF_RoB_index}.
  - Same rd in the same cycle: rename wins over commit clear; the value is still written.
  - Flush (RoBRF_pre_judge == 0): all 32 tags <= NON_DEP; the rename request is dropped; the commit value write still occurs.
- Latency: lookup is zero-cycle. Rename and commit are visible in state one edge later and are bypassed in the same cycle.
- No handshake back-pressure: every rename and commit request is accepted unconditionally.

Test Plan:
- Reset, then lookup rs1=5, rs2=NON_REG → Qj=16, Vj=0, Qk=16, Vk=0.
- Rename: DPRF_en=1, rd=7, idx=3; same cycle lookup rs1=7 → Qj=3 (bypass). Next cycle lookup rs1=7 → Qj=3 from state.
- Commit: with tag[7]=3, RoBRF_en=1, rd=7, idx=3, value=0xDEADBEEF. Same-cycle lookup → Qj=16, Vj=0xDEADBEEF. After the edge → tag[7]=16, value[7]=0xDEADBEEF.
- Rename/commit race: tag[7]=3; one cycle with commit (rd=7, idx=3, val=0x11) and rename (rd=7, idx=9). After the edge → tag[7]=9, value[7]=0x11.
- Stale commit: tag[7]=9; commit rd=7, idx=3, val=0x22 → value[7]=0x22, tag[7] stays 9.
- Flush: tags set on x1–x4; pre_judge=0 with commit rd=1, val=0x40 and rename rd=2 → all tags=16, value[1]=0x40, rename not recorded. Writes to x0 leave value 0; asserting reset mid-run clears everything immediately.

Source files
------------

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags.
// Zero-cycle operand lookup with rename and commit bypass.
module register_file #(
   parameter int REG_WIDTH    = 5,
   parameter int EX_REG_WIDTH = 6,
   parameter int NON_REG      = 32,
   parameter int RoB_WIDTH    = 4,
   parameter int EX_RoB_WIDTH = 5,
   parameter int NON_DEP      = 16
) (
   input  logic                    Sys_clk,
   input  logic                    Sys_rst_n,
   input  logic                    Sys_rdy,
   input  logic [EX_REG_WIDTH-1:0] DPRF_rs1,
   input  logic [EX_REG_WIDTH-1:0] DPRF_rs2,
   output logic [EX_RoB_WIDTH-1:0] RFDP_Qj,
   output logic [EX_RoB_WIDTH-1:0] RFDP_Qk,
   output logic [31:0]             RFDP_Vj,
   output logic [31:0]             RFDP_Vk,
   input  logic                    DPRF_en,
   input  logic [EX_REG_WIDTH-1:0] DPRF_rd,
   input  logic [RoB_WIDTH-1:0]    DPRF_RoB_index,
   input  logic                    RoBRF_en,
   input  logic [EX_REG_WIDTH-1:0] RoBRF_rd,
   input  logic [RoB_WIDTH-1:0]    RoBRF_RoB_index,
   input  logic [31:0]             RoBRF_value,
   input  logic                    RoBRF_pre_judge
);

   localparam int NREGS = 1 << REG_WIDTH;
   localparam logic [EX_REG_WIDTH-1:0] NOREG = EX_REG_WIDTH'(NON_REG);
   localparam logic [EX_RoB_WIDTH-1:0] NODEP = EX_RoB_WIDTH'(NON_DEP);

   logic [31:0]             value [NREGS];
   logic [EX_RoB_WIDTH-1:0] tag   [NREGS];

   logic [EX_RoB_WIDTH-1:0] rename_tag;
   logic [EX_RoB_WIDTH-1:0] commit_tag;
   logic [REG_WIDTH-1:0]    rename_idx;
   logic [REG_WIDTH-1:0]    commit_idx;
   logic                    rename_ok;
   logic                    commit_ok;

   assign rename_tag = {1'b0, DPRF_RoB_index};
   assign commit_tag = {1'b0, RoBRF_RoB_index};
   assign rename_idx = DPRF_rd[REG_WIDTH-1:0];
   assign commit_idx = RoBRF_rd[REG_WIDTH-1:0];

   // indices at or above NON_REG never name a real register
   assign rename_ok = DPRF_en && RoBRF_pre_judge
                   && DPRF_rd < NOREG && DPRF_rd != '0;
   assign commit_ok = RoBRF_en
                   && RoBRF_rd < NOREG && RoBRF_rd != '0;

   function automatic logic [EX_RoB_WIDTH+31:0] lookup(
      input logic [EX_REG_WIDTH-1:0] rs
   );
      logic [REG_WIDTH-1:0] r;
      logic                 hit;
      r   = rs[REG_WIDTH-1:0];
      hit = RoBRF_en && RoBRF_rd == rs && tag[r] == commit_tag;
      if (rs >= NOREG || rs == '0)
         lookup = {NODEP, 32'h0};
      else if (!RoBRF_pre_judge)
         lookup = {NODEP, hit ? RoBRF_value : value[r]};
      else if (DPRF_en && DPRF_rd == rs)
         lookup = {rename_tag, 32'h0};
      else if (hit)
         lookup = {NODEP, RoBRF_value};
      else
         lookup = {tag[r], value[r]};
   endfunction

   always_comb begin
      {RFDP_Qj, RFDP_Vj} = lookup(DPRF_rs1);
      {RFDP_Qk, RFDP_Vk} = lookup(DPRF_rs2);
   end

   always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
      if (!Sys_rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            value[i] <= '0;
            tag[i]   <= NODEP;
         end
      end else if (Sys_rdy) begin
         if (commit_ok)
            value[commit_idx] <= RoBRF_value;
         if (!RoBRF_pre_judge) begin
            for (int i = 0; i < NREGS; i++)
               tag[i] <= NODEP;
         end else begin
            // a younger rename owns the tag; clear only on match
            if (commit_ok && tag[commit_idx] == commit_tag)
               tag[commit_idx] <= NODEP;
            if (rename_ok)
               tag[rename_idx] <= rename_tag;
         end
      end
   end

endmodule
